// File: rtl/alu_bist_ctrl_if.sv
// ALU operand/control bus between the BIST sequencer and the ALU.
// The sequencer is the master; the ALU returns result and zero.
interface alu_bist_ctrl_if;
  logic [31:0] Src_A;
  logic [31:0] Src_B;
  logic [2:0]  ALUcontrol;
  logic [31:0] ALUResult;
  logic        zero;

  modport master (
    output Src_A,
    output Src_B,
    output ALUcontrol,
    input  ALUResult,
    input  zero
  );

  modport slave (
    input  Src_A,
    input  Src_B,
    input  ALUcontrol,
    output ALUResult,
    output zero
  );
endinterface

// File: rtl/alu_bist_ctrl.sv
// ALU BIST sequencer: LFSR operands per opcode, MISR compaction
// of result/zero, final signature compare against a golden value.
module alu_bist_ctrl #(
  parameter int          N_VECTORS  = 64,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2024,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000,
  parameter logic [31:0] POLY       = 32'h8020_0003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  alu_bist_ctrl_if.master bus,
  output logic        bist_mode,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);

  localparam int VW = $clog2(N_VECTORS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_FLUSH,
    S_CMP,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [31:0]   r_lfsr;
  logic [31:0]   r_misr;
  logic [VW-1:0] r_vec_cnt;
  logic [2:0]    r_op_idx;
  logic [31:0]   r_src_a;
  logic [31:0]   r_src_b;
  logic [2:0]    r_ctl;
  logic          r_cap;
  logic          r_bist;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [31:0]   r_sig;

  logic [31:0]   w_lfsr_nxt;
  logic [31:0]   w_misr_nxt;
  logic [31:0]   w_swap;
  logic [2:0]    w_vlo;
  logic          w_eq_ops;
  logic          w_last_vec;
  logic [2:0]    w_opc;

  assign w_lfsr_nxt = {r_lfsr[30:0], 1'b0}
                    ^ (r_lfsr[31] ? POLY : 32'd0);
  assign w_misr_nxt = {r_misr[30:0], 1'b0}
                    ^ (r_misr[31] ? POLY : 32'd0)
                    ^ bus.ALUResult
                    ^ {31'd0, bus.zero};
  assign w_swap     = {r_lfsr[15:0], r_lfsr[31:16]};
  assign w_vlo      = 3'(r_vec_cnt);
  // Every 8th vector uses equal operands to hit the sub/zero path
  assign w_eq_ops   = (w_vlo == 3'b111);
  assign w_last_vec = (r_vec_cnt == VW'(N_VECTORS - 1));

  always_comb begin
    w_opc = 3'b000;
    unique case (1'b1)
      (r_op_idx == 3'd1): w_opc = 3'b001;
      (r_op_idx == 3'd2): w_opc = 3'b010;
      (r_op_idx == 3'd3): w_opc = 3'b011;
      (r_op_idx == 3'd4): w_opc = 3'b101;
      default:            w_opc = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= '0;
      r_misr    <= '0;
      r_vec_cnt <= '0;
      r_op_idx  <= '0;
      r_src_a   <= '0;
      r_src_b   <= '0;
      r_ctl     <= '0;
      r_cap     <= 1'b0;
      r_bist    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_sig     <= '0;
    end else begin
      // Result of the vector driven on the previous edge
      if (r_cap)
        r_misr <= w_misr_nxt;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_SEED;
            r_bist  <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_sig   <= '0;
          end
        end
        S_SEED: begin
          r_lfsr    <= LFSR_SEED;
          r_misr    <= '0;
          r_vec_cnt <= '0;
          r_op_idx  <= '0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          r_src_a <= r_lfsr;
          r_src_b <= w_eq_ops ? r_lfsr : w_swap;
          r_ctl   <= w_opc;
          r_lfsr  <= w_lfsr_nxt;
          r_cap   <= 1'b1;
          if (w_last_vec) begin
            r_vec_cnt <= '0;
            if (r_op_idx == 3'd4)
              r_state <= S_FLUSH;
            else
              r_op_idx <= r_op_idx + 3'd1;
          end else begin
            r_vec_cnt <= r_vec_cnt + VW'(1);
          end
        end
        S_FLUSH: begin
          r_src_a <= '0;
          r_src_b <= '0;
          r_ctl   <= '0;
          r_cap   <= 1'b0;
          r_bist  <= 1'b0;
          r_state <= S_CMP;
        end
        S_CMP: begin
          r_sig   <= r_misr;
          r_pass  <= (r_misr == GOLDEN_SIG);
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Src_A      = r_src_a;
  assign bus.Src_B      = r_src_b;
  assign bus.ALUcontrol = r_ctl;
  assign bist_mode      = r_bist;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign signature      = r_sig;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: ALU model, fault injection and a
// vector/signature reference model built from the opcode schedule.
module tb_alu_bist_ctrl;

  localparam int          N0   = 64;
  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] G0   = 32'h0000_0000;

  function automatic logic [31:0] alu_ref(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a | b;
      3'b011:  return a & b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] op_code(input int op);
    case (op)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b011;
      default: return 3'b101;
    endcase
  endfunction

  function automatic logic [31:0] step(input logic [31:0] x);
    return (x << 1) ^ (x[31] ? POLY : 32'd0);
  endfunction

  function automatic logic [31:0] model_sig(input int nv, input int fidx);
    logic [31:0] l;
    logic [31:0] m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    int          k;
    l = SEED;
    m = 32'd0;
    k = 0;
    for (int op = 0; op < 5; op++) begin
      for (int v = 0; v < nv; v++) begin
        a = l;
        b = (v % 8 == 7) ? l : {l[15:0], l[31:16]};
        r = alu_ref(a, b, op_code(op));
        z = (r == 32'd0);
        if (k == fidx) r = r ^ 32'd1;
        m = step(m) ^ r ^ {31'd0, z};
        l = step(l);
        k++;
      end
    end
    return m;
  endfunction

  localparam logic [31:0] G1 = model_sig(1, -1);

  logic clk = 1'b0;
  logic rst;
  logic start0;
  logic start1;
  logic bm0, busy0, done0, pass0;
  logic bm1, busy1, done1, pass1;
  logic [31:0] sig0;
  logic [31:0] sig1;
  logic        fault_en;
  logic [31:0] fault_a;
  logic [102:0] outs0;

  int checks = 0;
  int failures = 0;

  logic [31:0] va [0:319];
  logic [31:0] vb [0:319];
  logic [2:0]  vc [0:319];

  alu_bist_ctrl_if bus0();
  alu_bist_ctrl_if bus1();

  assign bus0.ALUResult =
    alu_ref(bus0.Src_A, bus0.Src_B, bus0.ALUcontrol)
    ^ {31'd0, fault_en && bm0 && bus0.Src_A == fault_a
              && bus0.ALUcontrol == 3'b001};
  assign bus0.zero =
    alu_ref(bus0.Src_A, bus0.Src_B, bus0.ALUcontrol) == 32'd0;
  assign bus1.ALUResult =
    alu_ref(bus1.Src_A, bus1.Src_B, bus1.ALUcontrol);
  assign bus1.zero = bus1.ALUResult == 32'd0;

  assign outs0 = {bm0, busy0, done0, pass0, sig0,
                  bus0.Src_A, bus0.Src_B, bus0.ALUcontrol};

  alu_bist_ctrl #(
    .N_VECTORS(N0), .LFSR_SEED(SEED),
    .GOLDEN_SIG(G0), .POLY(POLY)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(bus0),
    .bist_mode(bm0), .busy(busy0), .done(done0),
    .pass(pass0), .signature(sig0)
  );

  alu_bist_ctrl #(
    .N_VECTORS(1), .LFSR_SEED(SEED),
    .GOLDEN_SIG(G1), .POLY(POLY)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1),
    .bist_mode(bm1), .busy(busy1), .done(done1),
    .pass(pass1), .signature(sig1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic gen_vectors(input int nv);
    logic [31:0] l;
    int k;
    l = SEED;
    k = 0;
    for (int op = 0; op < 5; op++) begin
      for (int v = 0; v < nv; v++) begin
        va[k] = l;
        vb[k] = (v % 8 == 7) ? l : {l[15:0], l[31:16]};
        vc[k] = op_code(op);
        l = step(l);
        k++;
      end
    end
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 6)) tick();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    fault_en = 1'b0;
    fault_a = 32'd0;
    tick();
    tick();
    checks++;
    if (outs0 !== 103'd0)
      $display("FAIL reset_hold outs=%h want 0", outs0);
    rst = 1'b0;
    n = $urandom_range(5, 20);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (busy0 !== 1'b0) begin
        failures++;
        $display("FAIL idle_busy busy=%b want 0", busy0);
      end
    end
    pulse0();
    repeat ($urandom_range(10, 40)) tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if (outs0 !== 103'd0) begin
      failures++;
      $display("FAIL async_reset outs=%h want 0", outs0);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (outs0 !== 103'd0) begin
      failures++;
      $display("FAIL post_reset outs=%h want 0", outs0);
    end
  endtask

  task automatic test_main();
    logic [31:0] exp;
    int ed;
    int nv;
    nv = 5 * N0;
    exp = model_sig(N0, -1);
    pulse0();
    checks++;
    if ({busy0, bm0, done0} !== 3'b110) begin
      failures++;
      $display("FAIL start_ack bdd=%b want 110", {busy0, bm0, done0});
    end
    tick();
    checks++;
    if (bus0.Src_A !== 32'd0 || bus0.ALUcontrol !== 3'd0) begin
      failures++;
      $display("FAIL seed_ops a=%h want 0", bus0.Src_A);
    end
    ed = -1;
    for (int e = 2; e <= 400; e++) begin
      tick();
      if (e - 2 < nv) begin
        checks++;
        if ({bus0.Src_A, bus0.Src_B, bus0.ALUcontrol, bm0} !==
            {va[e-2], vb[e-2], vc[e-2], 1'b1}) begin
          failures++;
          $display("FAIL vec%0d a=%h b=%h c=%b want %h %h %b", e - 2,
                   bus0.Src_A, bus0.Src_B, bus0.ALUcontrol,
                   va[e-2], vb[e-2], vc[e-2]);
        end
        if (e - 2 == N0 + 7) begin
          checks++;
          if (bus0.Src_B !== bus0.Src_A || bus0.zero !== 1'b1 ||
              bus0.ALUcontrol !== 3'b001) begin
            failures++;
            $display("FAIL sub_eq a=%h b=%h z=%b want equal z=1",
                     bus0.Src_A, bus0.Src_B, bus0.zero);
          end
        end
      end
      if (e - 2 == nv) begin
        checks++;
        if ({bm0, busy0, bus0.Src_A, bus0.ALUcontrol} !==
            {1'b0, 1'b1, 32'd0, 3'd0}) begin
          failures++;
          $display("FAIL flush_out bm=%b busy=%b a=%h want 0 1 0",
                   bm0, busy0, bus0.Src_A);
        end
      end
      if (done0 === 1'b1) begin
        ed = e;
        break;
      end
    end
    checks++;
    if (ed != nv + 3) begin
      failures++;
      $display("FAIL done_edge got=%0d want %0d", ed, nv + 3);
    end
    checks++;
    if (sig0 !== exp || pass0 !== (exp == G0) || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL main_sig sig=%h pass=%b want %h %b",
               sig0, pass0, exp, exp == G0);
    end
  endtask

  task automatic test_fault();
    logic [31:0] expf;
    int ed;
    expf = model_sig(N0, 100);
    fault_a = va[100];
    fault_en = 1'b1;
    pulse0();
    ed = -1;
    for (int e = 1; e <= 400; e++) begin
      tick();
      if (done0 === 1'b1) begin
        ed = e;
        break;
      end
    end
    fault_en = 1'b0;
    checks++;
    if (ed != 5 * N0 + 3) begin
      failures++;
      $display("FAIL fault_done got=%0d want %0d", ed, 5 * N0 + 3);
    end
    checks++;
    if (sig0 !== expf || pass0 !== (expf == G0)) begin
      failures++;
      $display("FAIL fault_sig sig=%h pass=%b want %h %b",
               sig0, pass0, expf, expf == G0);
    end
    checks++;
    if (sig0 === model_sig(N0, -1)) begin
      failures++;
      $display("FAIL fault_diff sig=%h want != clean", sig0);
    end
  endtask

  task automatic test_busy_start();
    int es;
    int ed;
    es = $urandom_range(3, 300);
    pulse0();
    ed = -1;
    for (int e = 1; e <= 400; e++) begin
      start0 = (e == es);
      tick();
      start0 = 1'b0;
      if (done0 === 1'b1) begin
        ed = e;
        break;
      end
    end
    checks++;
    if (ed != 5 * N0 + 3 || sig0 !== model_sig(N0, -1)) begin
      failures++;
      $display("FAIL busy_start edge=%0d sig=%h want %0d %h",
               ed, sig0, 5 * N0 + 3, model_sig(N0, -1));
    end
  endtask

  task automatic test_reset_midrun();
    int er;
    int ed;
    er = $urandom_range(3, 320);
    pulse0();
    repeat (er) tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if (outs0 !== 103'd0) begin
      failures++;
      $display("FAIL midrun_rst outs=%h want 0", outs0);
    end
    tick();
    rst = 1'b0;
    gap();
    checks++;
    if (outs0 !== 103'd0) begin
      failures++;
      $display("FAIL rst_idle outs=%h want 0", outs0);
    end
    pulse0();
    ed = -1;
    for (int e = 1; e <= 400; e++) begin
      tick();
      if (done0 === 1'b1) begin
        ed = e;
        break;
      end
    end
    checks++;
    if (ed != 5 * N0 + 3 || sig0 !== model_sig(N0, -1)) begin
      failures++;
      $display("FAIL rerun edge=%0d sig=%h want %0d %h",
               ed, sig0, 5 * N0 + 3, model_sig(N0, -1));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    int ed;
    prev = sig0;
    pulse0();
    checks++;
    if ({done0, pass0, sig0, busy0} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL restart_clr done=%b sig=%h busy=%b want 0 0 1",
               done0, sig0, busy0);
    end
    ed = -1;
    for (int e = 1; e <= 400; e++) begin
      tick();
      if (done0 === 1'b1) begin
        ed = e;
        break;
      end
    end
    checks++;
    if (ed != 5 * N0 + 3 || sig0 !== prev) begin
      failures++;
      $display("FAIL b2b edge=%0d sig=%h want %0d %h",
               ed, sig0, 5 * N0 + 3, prev);
    end
  endtask

  task automatic test_n1();
    logic [31:0] l;
    int ed;
    l = SEED;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    ed = -1;
    for (int e = 2; e <= 40; e++) begin
      tick();
      if (e - 2 < 5) begin
        checks++;
        if ({bus1.Src_A, bus1.Src_B, bus1.ALUcontrol} !==
            {l, l[15:0], l[31:16], op_code(e - 2)}) begin
          failures++;
          $display("FAIL n1_vec%0d a=%h b=%h c=%b want %h %b", e - 2,
                   bus1.Src_A, bus1.Src_B, bus1.ALUcontrol,
                   l, op_code(e - 2));
        end
        l = step(l);
      end
      if (done1 === 1'b1) begin
        ed = e;
        break;
      end
    end
    checks++;
    if (ed != 8) begin
      failures++;
      $display("FAIL n1_done got=%0d want 8", ed);
    end
    checks++;
    if (sig1 !== model_sig(1, -1) || pass1 !== 1'b1) begin
      failures++;
      $display("FAIL n1_sig sig=%h pass=%b want %h 1",
               sig1, pass1, model_sig(1, -1));
    end
  endtask

  initial begin
    gen_vectors(N0);
    test_reset();
    gap();
    test_main();
    gap();
    test_fault();
    gap();
    test_busy_start();
    gap();
    test_reset_midrun();
    gap();
    test_back_to_back();
    gap();
    test_n1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
